fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage and IF/ID pipeline register that feeds the instruction decoder. It maintains the SPARC-style PC/nPC pair and runs a req/ack handshake with instruction memory. It holds the fetched word in a one-entry hold buffer when decode is stalled. It presents `instr_ID`/`pc_ID` to decode and inserts the all-zero word, which decodes as `nop`, as a bubble.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; nPC resets to `RESET_PC+4`.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address (= PC).
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `stall_ID`  in  1  decode cannot accept; IF/ID holds.
- `flush_ID`  in  1  replace IF/ID contents with bubble.
- `redirect_valid`  in  1  one-cycle pulse from EX (bne taken / call / jmpl).
- `redirect_target`  in  32  new nPC; bits [1:0] forced to 00.
- `instr_ID`  out  32  instruction to decode.
- `pc_ID`  out  32  PC of `instr_ID`.
- `valid_ID`  out  1  `instr_ID` is a real fetched instruction.

## Operation
- Reset values:
  - PC=`RESET_PC`, nPC=`RESET_PC+4`.
  - `instr_ID`=0, `pc_ID`=0, `valid_ID`=0, `imem_req`=0.
  - Hold buffer empty, redirect-pending clear, state FETCH.
- FSM states: FETCH, HOLD.
- FETCH:
  - `imem_req`=1, `imem_addr`=PC.
  - On `imem_ack`, PC advances: PC<=nPC; nPC<=redirect target if one is pending or arriving, else nPC+4.
  - On `imem_ack` with `stall_ID`=0: IF/ID loads {`imem_rdata`, PC, valid=1}; stay in FETCH.
  - On `imem_ack` with `stall_ID`=1: word and PC go to the hold buffer; go to HOLD.
  - No ack: nothing advances.
- HOLD:
  - `imem_req`=0.
  - When `stall_ID`=0: IF/ID loads from the hold buffer, buffer empties, go to FETCH.
- Redirect:
  - Latched into redirect-pending (target stored) and applied at the next PC advance, then cleared.
  - Only the nPC changes, so the word at the current nPC (delay slot) is still fetched.
  - A new redirect arriving while one is pending overwrites it.
- Flush:
  - `flush_ID` sets IF/ID to {0, 0, valid=0} regardless of `stall_ID` (flush wins).
  - The hold buffer is not affected.
- Stall without flush: IF/ID holds its value unchanged.
- Arithmetic: PC/nPC +4 wrap modulo 2^32 (nPC=32'hFFFF_FFFC advances to 0).
- `rst` asserted mid-handshake: returns to reset values next edge. An `imem_ack` in the reset cycle is ignored.

## Timing
- Handshake: once `imem_req` rises, `imem_req`/`imem_addr` stay stable until the cycle `imem_ack`=1 is sampled. A redirect never changes an outstanding address.
- Zero-wait memory (ack every cycle): one instruction per cycle. IF/ID shows the word at the edge after the ack.
- First request: the cycle after `rst` deasserts. `imem_addr`=`RESET_PC`.
- HOLD→FETCH: the new request is issued the cycle after the stall releases (one bubble-free resume, one request gap).
- Outputs are registered, with no combinational path from inputs to `instr_ID`/`pc_ID`/`valid_ID`. `imem_req` depends on state only.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds outputs `perf_fetch_cnt[31:0]`, incremented per accepted `imem_ack`.
  - Adds outputs `perf_stall_cnt[31:0]`, incremented per cycle with `stall_ID`=1.
  - Both wrap modulo 2^32 and reset to 0.
- Not defined: ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `fetch_pkg`: state enum {FETCH, HOLD}, `NOP_INSTR`=32'h0, `PC_STEP`=32'd4.
- Sub-module `fetch_hold_buf`: one-entry buffer {instr, pc, full} with load/drain. Everything else lives in `fetch_stage`.

## Test plan
- Reset release, ack every cycle, `RESET_PC`=0 -> `imem_addr` 0,4,8,…; `pc_ID` follows one cycle later with `valid_ID`=1.
- Ack delayed 3 cycles at addr 8 -> `imem_req`/`imem_addr`=8 held for 4 cycles; IF/ID unchanged until the ack.
- `stall_ID`=1 for 3 cycles when the word at 12 is acked -> HOLD, `imem_req`=0, IF/ID holds 8. On release, `pc_ID`=12, then fetch resumes at 16.
- `redirect_valid` with target 32'h100 while PC=20, nPC=24 -> fetch sequence 20, 24, 32'h100, 32'h104.
- `flush_ID` and `stall_ID` both high -> next cycle `instr_ID`=0, `valid_ID`=0; hold buffer contents delivered after the stall drops.
- PC near wrap (nPC=32'hFFFF_FFFC), plus `rst` mid-request -> address wraps to 0. Reset returns all outputs to reset values and the next request is at `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry buffer parking a fetched word while decode is stalled
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        full_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        full_q, full_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        full_d  = full_q;
        if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            full_d  = 1'b1;
        end else if (drain_i) begin
            full_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0;
            full_q  <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            full_q  <= full_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign full_o  = full_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC/nPC fetch with imem req/ack and IF/ID register
// Optional performance counters when FETCH_PERF_EN is defined.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_ID,
    input  logic        flush_ID,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic [31:0] instr_ID,
    output logic [31:0] pc_ID,
    output logic        valid_ID
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  npc_q, npc_d;
    logic         req_q, req_d;
    logic         redir_pend_q, redir_pend_d;
    logic [31:0]  redir_tgt_q, redir_tgt_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pcid_q, pcid_d;
    logic         valid_q, valid_d;

    logic [31:0]  tgt_in;
    logic         accept;
    logic         buf_load;
    logic         buf_drain;
    logic [31:0]  buf_instr;
    logic [31:0]  buf_pc;
    logic         buf_full;

    assign tgt_in    = redirect_target & ~32'h3;
    // req_q is low in the first cycle after reset, so an ack there is ignored
    assign accept    = (state_q == FETCH) && req_q && imem_ack;
    assign buf_load  = accept && stall_ID;
    assign buf_drain = (state_q == HOLD) && !stall_ID && buf_full;

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .drain_i (buf_drain),
        .instr_i (imem_rdata),
        .pc_i    (pc_q),
        .instr_o (buf_instr),
        .pc_o    (buf_pc),
        .full_o  (buf_full)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        npc_d        = npc_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;
        instr_d      = instr_q;
        pcid_d       = pcid_q;
        valid_d      = valid_q;

        // Only nPC is redirected, so the delay-slot word at the old nPC is still fetched
        if (accept) begin
            pc_d         = npc_q;
            redir_pend_d = 1'b0;
            if (redirect_valid)
                npc_d = tgt_in;
            else if (redir_pend_q)
                npc_d = redir_tgt_q;
            else
                npc_d = npc_q + PC_STEP;
        end else if (redirect_valid) begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = tgt_in;
        end

        case (state_q)
            FETCH: begin
                if (accept) begin
                    if (stall_ID) begin
                        state_d = HOLD;
                    end else begin
                        instr_d = imem_rdata;
                        pcid_d  = pc_q;
                        valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!stall_ID) begin
                    instr_d = buf_instr;
                    pcid_d  = buf_pc;
                    valid_d = buf_full;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        if (flush_ID) begin
            instr_d = NOP_INSTR;
            pcid_d  = 32'h0;
            valid_d = 1'b0;
        end

        req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            npc_q        <= RESET_PC + PC_STEP;
            req_q        <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= 32'h0;
            instr_q      <= NOP_INSTR;
            pcid_q       <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            npc_q        <= npc_d;
            req_q        <= req_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
            instr_q      <= instr_d;
            pcid_q       <= pcid_d;
            valid_q      <= valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (accept)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_ID)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign instr_ID  = instr_q;
    assign pc_ID     = pcid_q;
    assign valid_ID  = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall_ID;
    logic        flush_ID;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr_ID;
    logic [31:0] pc_ID;
    logic        valid_ID;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];

    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc    = 32'h0;
    logic [31:0] prev_instr = 32'h0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hA5A5_0F0F;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .stall_ID        (stall_ID),
        .flush_ID        (flush_ID),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt),
`endif
        .instr_ID        (instr_ID),
        .pc_ID           (pc_ID),
        .valid_ID        (valid_ID)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        exp_addr_q.push_back(a);
        exp_pc_q.push_back(a);
    endtask

    task automatic set(input logic a, input logic s, input logic f);
        @(posedge clk);
        #1;
        imem_ack       = a;
        stall_ID       = s;
        flush_ID       = f;
        redirect_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'h0, imem_req}, 32'h0);
        check({tag, "_valid"}, {31'h0, valid_ID}, 32'h0);
        check({tag, "_instr"}, instr_ID, 32'h0);
        check({tag, "_pc_id"}, pc_ID, 32'h0);
        check({tag, "_addr"},  imem_addr, 32'h0);
    endtask

    // Monitor: pops the scoreboard on every accepted fetch and every new IF/ID entry
    always @(negedge clk) begin
        if (!rst && imem_req && imem_ack) begin
            if (exp_addr_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_fetch: addr %h with empty queue", imem_addr);
            end else begin
                check("fetch_addr", imem_addr, exp_addr_q.pop_front());
            end
        end
        if (valid_ID && (!prev_valid || pc_ID != prev_pc || instr_ID != prev_instr)) begin
            if (exp_pc_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_id: pc_ID %h with empty queue", pc_ID);
            end else begin
                logic [31:0] epc;
                epc = exp_pc_q.pop_front();
                check("pc_ID", pc_ID, epc);
                check("instr_ID", instr_ID, mem_word(epc));
            end
        end
        prev_valid <= valid_ID;
        prev_pc    <= pc_ID;
        prev_instr <= instr_ID;
    end

    initial begin
        rst             = 1'b1;
        imem_ack        = 1'b0;
        stall_ID        = 1'b0;
        flush_ID        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        repeat (2) @(posedge clk);

        set(0, 0, 0);
        check_reset_outputs("reset");
        set(0, 0, 0); rst = 1'b0;
        check("first_cycle_no_req", {31'h0, imem_req}, 32'h0);

        // Zero-wait fetches of 0 and 4
        set(1, 0, 0); expect_fetch(32'h0);
        check("first_req", {31'h0, imem_req}, 32'h1);
        set(1, 0, 0); expect_fetch(32'h4);

        // Ack delayed 3 cycles at address 8
        for (int i = 0; i < 3; i++) begin
            set(0, 0, 0);
            check("wait_req", {31'h0, imem_req}, 32'h1);
            check("wait_addr", imem_addr, 32'h8);
            check("wait_pc_id", pc_ID, 32'h4);
        end
        set(1, 0, 0); expect_fetch(32'h8);
        check("ack_addr", imem_addr, 32'h8);

        // Stall while word 12 is acked
        set(1, 1, 0); expect_fetch(32'hC);
        for (int i = 0; i < 2; i++) begin
            set(0, 1, 0);
            check("hold_req", {31'h0, imem_req}, 32'h0);
            check("hold_pc_id", pc_ID, 32'h8);
        end
        set(0, 0, 0);
        check("release_req", {31'h0, imem_req}, 32'h0);
        set(1, 0, 0); expect_fetch(32'h10);
        check("resume_pc_id", pc_ID, 32'hC);
        check("resume_addr", imem_addr, 32'h10);

        // Redirect at PC=20/nPC=24; low target bits must be masked
        set(1, 0, 0); expect_fetch(32'h14);
        redirect_valid = 1'b1; redirect_target = 32'h0000_0103;
        set(1, 0, 0); expect_fetch(32'h18);
        set(1, 0, 0); expect_fetch(32'h100);
        set(1, 0, 0); expect_fetch(32'h104);

        // Flush with stall in HOLD: bubble, then buffered word 0x108
        set(1, 1, 0); expect_fetch(32'h108);
        set(0, 1, 1);
        check("pre_flush_pc_id", pc_ID, 32'h104);
        set(0, 1, 0);
        check("flush_instr", instr_ID, 32'h0);
        check("flush_valid", {31'h0, valid_ID}, 32'h0);
        check("flush_pc_id", pc_ID, 32'h0);
        check("flush_hold_req", {31'h0, imem_req}, 32'h0);
        set(0, 0, 0);
        set(1, 0, 0); expect_fetch(32'h10C);
        check("post_flush_pc_id", pc_ID, 32'h108);
        check("post_flush_valid", {31'h0, valid_ID}, 32'h1);
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF8;

        // Wrap: ..., FFFFFFF8, FFFFFFFC, 0
        set(1, 0, 0); expect_fetch(32'h110);
        set(1, 0, 0); expect_fetch(32'hFFFF_FFF8);
        set(1, 0, 0); expect_fetch(32'hFFFF_FFFC);
        set(0, 0, 0);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_req", {31'h0, imem_req}, 32'h1);

        // Reset mid-request with an ack that must be ignored
        set(1, 0, 0); rst = 1'b1;
        set(0, 0, 0); rst = 1'b0;
        check_reset_outputs("mid_reset");
        set(1, 0, 0); expect_fetch(32'h0);
        check("post_reset_req", {31'h0, imem_req}, 32'h1);
        check("post_reset_addr", imem_addr, 32'h0);
        set(1, 0, 0); expect_fetch(32'h4);
        repeat (3) set(0, 0, 0);

        check("addr_queue_empty", exp_addr_q.size(), 32'h0);
        check("id_queue_empty", exp_pc_q.size(), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
